// File: rtl/intersection_traffic_model.sv
// rtl/intersection_traffic_model.sv - five-lane intersection plant model with safety flags

package light_package;
  typedef enum logic [1:0] {
    red    = 2'd0,
    yellow = 2'd1,
    green  = 2'd2
  } colors;
endpackage

module intersection_traffic_model
  import light_package::*;
#(
  parameter  int QDEPTH     = 15,
  parameter  int DEPART_GAP = 1,
  parameter  int CNT_W      = 16,
  localparam int QW         = $clog2(QDEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             e_left_arrive,
  input  logic             e_str_arrive,
  input  logic             w_left_arrive,
  input  logic             w_str_arrive,
  input  logic             ns_arrive,
  input  colors            e_left_light,
  input  colors            e_str_light,
  input  colors            w_left_light,
  input  colors            w_str_light,
  input  colors            ns_light,
  output logic             e_left_sensor,
  output logic             e_str_sensor,
  output logic             w_left_sensor,
  output logic             w_str_sensor,
  output logic             ns_sensor,
  output logic [QW-1:0]    e_left_q,
  output logic [QW-1:0]    e_str_q,
  output logic [QW-1:0]    w_left_q,
  output logic [QW-1:0]    w_str_q,
  output logic [QW-1:0]    ns_q,
  output logic [CNT_W-1:0] departed_total,
  output logic             conflict,
  output logic             overflow
);

  // Lane index order used throughout: 0 e_left, 1 e_str, 2 w_left, 3 w_str, 4 ns.
  localparam int              GW       = 4;
  localparam logic [QW-1:0]   QMAX     = QW'(QDEPTH);
  localparam logic [GW-1:0]   GAP_LOAD = GW'(DEPART_GAP - 1);

  logic [4:0]       arrive;
  colors            light [5];
  logic [4:0]       is_green;
  logic [4:0]       active;
  logic [4:0]       dep;
  logic [4:0]       drop;
  logic [2:0]       dep_cnt;
  logic             bad_combo;

  logic [QW-1:0]    cnt_q [5];
  logic [QW-1:0]    cnt_d [5];
  logic [GW-1:0]    gap_q [5];
  logic [GW-1:0]    gap_d [5];
  logic [CNT_W-1:0] total_q, total_d;
  logic             conflict_q, conflict_d;
  logic             overflow_q, overflow_d;

  assign arrive = {ns_arrive, w_str_arrive, w_left_arrive, e_str_arrive, e_left_arrive};

  assign light[0] = e_left_light;
  assign light[1] = e_str_light;
  assign light[2] = w_left_light;
  assign light[3] = w_str_light;
  assign light[4] = ns_light;

  // Per-lane queue/gap update, departure count and safety checks.
  always_comb begin
    is_green = '0;
    active   = '0;
    dep      = '0;
    drop     = '0;
    dep_cnt  = '0;
    for (int i = 0; i < 5; i++) begin
      cnt_d[i]    = cnt_q[i];
      gap_d[i]    = gap_q[i];
      is_green[i] = (light[i] == green);
      active[i]   = (light[i] != red);
      dep[i]      = is_green[i] && (cnt_q[i] != '0) && (gap_q[i] == '0);

      // Gap only runs while green; leaving green re-arms an immediate departure.
      if (!is_green[i]) begin
        gap_d[i] = '0;
      end else if (dep[i]) begin
        gap_d[i] = GAP_LOAD;
      end else if (gap_q[i] != '0) begin
        gap_d[i] = gap_q[i] - 1'b1;
      end

      // A departing car frees the slot the arriving car takes, so a full lane never drops then.
      if (dep[i] && !arrive[i]) begin
        cnt_d[i] = cnt_q[i] - 1'b1;
      end else if (!dep[i] && arrive[i]) begin
        if (cnt_q[i] < QMAX) begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end else begin
          drop[i] = 1'b1;
        end
      end

      dep_cnt = dep_cnt + {2'b00, dep[i]};
    end

    bad_combo  = (active[4] && (active[3:0] != 4'b0000)) ||
                 (active[0] && active[3]) ||
                 (active[1] && active[2]);
    total_d    = total_q + CNT_W'(dep_cnt);
    conflict_d = conflict_q | bad_combo;
    overflow_d = overflow_q | (|drop);
  end

  // State registers; reset empties the intersection immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 5; i++) begin
        cnt_q[i] <= '0;
        gap_q[i] <= '0;
      end
      total_q    <= '0;
      conflict_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      for (int i = 0; i < 5; i++) begin
        cnt_q[i] <= cnt_d[i];
        gap_q[i] <= gap_d[i];
      end
      total_q    <= total_d;
      conflict_q <= conflict_d;
      overflow_q <= overflow_d;
    end
  end

  assign e_left_q = cnt_q[0];
  assign e_str_q  = cnt_q[1];
  assign w_left_q = cnt_q[2];
  assign w_str_q  = cnt_q[3];
  assign ns_q     = cnt_q[4];

  assign e_left_sensor = (cnt_q[0] != '0);
  assign e_str_sensor  = (cnt_q[1] != '0);
  assign w_left_sensor = (cnt_q[2] != '0);
  assign w_str_sensor  = (cnt_q[3] != '0);
  assign ns_sensor     = (cnt_q[4] != '0);

  assign departed_total = total_q;
  assign conflict       = conflict_q;
  assign overflow       = overflow_q;

endmodule

// File: tb/tb_intersection_traffic_model.sv
// tb/tb_intersection_traffic_model.sv - self-checking bench for intersection_traffic_model

module tb_intersection_traffic_model;
  import light_package::*;

  localparam int QD  = 15;
  localparam int GAP = 2;
  localparam int CW  = 16;
  localparam int QW  = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [4:0]    arr;
  colors         lt [5];
  logic [QW-1:0] e_left_q, e_str_q, w_left_q, w_str_q, ns_q;
  logic          e_left_sensor, e_str_sensor, w_left_sensor, w_str_sensor, ns_sensor;
  logic [CW-1:0] departed_total;
  logic          conflict, overflow;

  logic [QW-1:0] dq [5];
  logic [4:0]    dsens;

  int checks = 0;
  int errors = 0;

  // Reference model: queues, departure times and green-run start times.
  int mq [5];
  int last_dep [5];
  int gstart [5];
  bit pgreen [5];
  int mtotal;
  bit mconf, movf;
  int cyc;

  bit [4:0] legal [5] = '{5'b10000, 5'b00011, 5'b01100, 5'b01010, 5'b00101};

  intersection_traffic_model #(.QDEPTH(QD), .DEPART_GAP(GAP), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .e_left_arrive(arr[0]), .e_str_arrive(arr[1]), .w_left_arrive(arr[2]),
    .w_str_arrive(arr[3]), .ns_arrive(arr[4]),
    .e_left_light(lt[0]), .e_str_light(lt[1]), .w_left_light(lt[2]),
    .w_str_light(lt[3]), .ns_light(lt[4]),
    .e_left_sensor(e_left_sensor), .e_str_sensor(e_str_sensor),
    .w_left_sensor(w_left_sensor), .w_str_sensor(w_str_sensor), .ns_sensor(ns_sensor),
    .e_left_q(e_left_q), .e_str_q(e_str_q), .w_left_q(w_left_q),
    .w_str_q(w_str_q), .ns_q(ns_q),
    .departed_total(departed_total), .conflict(conflict), .overflow(overflow)
  );

  always #5 clk = ~clk;

  assign dq[0] = e_left_q;
  assign dq[1] = e_str_q;
  assign dq[2] = w_left_q;
  assign dq[3] = w_str_q;
  assign dq[4] = ns_q;
  assign dsens = {ns_sensor, w_str_sensor, w_left_sensor, e_str_sensor, e_left_sensor};

  task automatic model_reset();
    for (int i = 0; i < 5; i++) begin
      mq[i] = 0; last_dep[i] = -1000; gstart[i] = 0; pgreen[i] = 1'b0;
    end
    mtotal = 0; mconf = 1'b0; movf = 1'b0;
  endtask

  task automatic all_red();
    for (int i = 0; i < 5; i++) lt[i] = red;
  endtask

  // Advance the model by the current inputs, then let the DUT take the same edge.
  task automatic step();
    int nd;
    bit g, d, ok;
    bit [4:0] act;
    nd = 0; act = '0;
    for (int i = 0; i < 5; i++) begin
      g = (lt[i] == green);
      if (g && !pgreen[i]) gstart[i] = cyc;
      d = g && (mq[i] > 0) && ((last_dep[i] < gstart[i]) || (cyc - last_dep[i] >= GAP));
      if (d) begin
        last_dep[i] = cyc;
        nd++;
        if (!arr[i]) mq[i]--;
      end else if (arr[i]) begin
        if (mq[i] < QD) mq[i]++;
        else movf = 1'b1;
      end
      pgreen[i] = g;
      act[i] = (lt[i] != red);
    end
    ok = (act == 5'b0);
    for (int k = 0; k < 5; k++) if ((act & ~legal[k]) == 5'b0) ok = 1'b1;
    if (!ok) mconf = 1'b1;
    mtotal = (mtotal + nd) % (1 << CW);
    cyc++;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 1'b0; arr = '0; all_red();
    model_reset();
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0; arr = '0; all_red();
    model_reset();
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (dq[i] !== 4'd0) begin errors++; $display("FAIL reset_q lane %0d got %0d want 0", i, dq[i]); end
    end
    checks++;
    if (dsens !== 5'b0) begin errors++; $display("FAIL reset_sensors got %b want 00000", dsens); end
    checks++;
    if (departed_total !== 16'd0) begin errors++; $display("FAIL reset_total got %0d want 0", departed_total); end
    checks++;
    if ({conflict, overflow} !== 2'b00) begin errors++; $display("FAIL reset_flags got %b want 00", {conflict, overflow}); end
    reset = 1'b1;
  endtask

  task automatic test_arrivals();
    do_reset();
    arr[4] = 1'b1;
    repeat (3) step();
    arr = '0;
    checks++;
    if (ns_q !== 4'd3) begin errors++; $display("FAIL arr_ns_q got %0d want 3", ns_q); end
    checks++;
    if (ns_sensor !== 1'b1) begin errors++; $display("FAIL arr_ns_sensor got %b want 1", ns_sensor); end
    checks++;
    if (departed_total !== 16'd0) begin errors++; $display("FAIL arr_total got %0d want 0", departed_total); end
    checks++;
    if ({conflict, overflow} !== 2'b00) begin errors++; $display("FAIL arr_flags got %b want 00", {conflict, overflow}); end
  endtask

  task automatic test_drain();
    int exp_q [6] = '{2, 2, 1, 1, 0, 0};
    lt[4] = green;
    for (int k = 0; k < 6; k++) begin
      step();
      checks++;
      if (ns_q !== exp_q[k][QW-1:0]) begin errors++; $display("FAIL drain_q cycle %0d got %0d want %0d", k, ns_q, exp_q[k]); end
    end
    checks++;
    if (ns_sensor !== 1'b0) begin errors++; $display("FAIL drain_sensor got %b want 0", ns_sensor); end
    checks++;
    if (departed_total !== 16'd3) begin errors++; $display("FAIL drain_total got %0d want 3", departed_total); end
    all_red();
  endtask

  task automatic test_overflow();
    do_reset();
    arr[1] = 1'b1;
    repeat (QD) step();
    checks++;
    if ({e_str_q, overflow} !== {4'd15, 1'b0}) begin errors++; $display("FAIL ovf_full got q=%0d ovf=%b want q=15 ovf=0", e_str_q, overflow); end
    step();
    checks++;
    if ({e_str_q, overflow} !== {4'd15, 1'b1}) begin errors++; $display("FAIL ovf_drop got q=%0d ovf=%b want q=15 ovf=1", e_str_q, overflow); end
    lt[1] = green;
    step();
    checks++;
    if ({e_str_q, overflow} !== {4'd15, 1'b1}) begin errors++; $display("FAIL ovf_swap got q=%0d ovf=%b want q=15 ovf=1", e_str_q, overflow); end
    checks++;
    if (departed_total !== 16'd1) begin errors++; $display("FAIL ovf_total got %0d want 1", departed_total); end
    arr = '0; all_red();
  endtask

  task automatic test_conflict();
    bit [4:0] pair_mask [6] = '{5'b10010, 5'b01001, 5'b00110, 5'b01010, 5'b00101, 5'b00011};
    bit       pair_bad  [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    do_reset();
    lt[4] = yellow; lt[1] = green;
    step();
    all_red();
    checks++;
    if (conflict !== 1'b1) begin errors++; $display("FAIL conf_set got %b want 1", conflict); end
    repeat (3) step();
    checks++;
    if (conflict !== 1'b1) begin errors++; $display("FAIL conf_sticky got %b want 1", conflict); end
    for (int p = 0; p < 6; p++) begin
      do_reset();
      for (int i = 0; i < 5; i++) lt[i] = pair_mask[p][i] ? green : red;
      repeat (2) step();
      all_red();
      checks++;
      if (conflict !== pair_bad[p]) begin errors++; $display("FAIL conf_pair %b got %b want %b", pair_mask[p], conflict, pair_bad[p]); end
    end
  endtask

  task automatic check_vs_model(input int n);
    logic [19:0] mpack, dpack;
    logic [4:0]  msens;
    for (int i = 0; i < 5; i++) begin
      mpack[4*i +: 4] = mq[i][3:0];
      dpack[4*i +: 4] = dq[i];
      msens[i] = (mq[i] != 0);
    end
    checks++;
    if (dpack !== mpack) begin errors++; $display("FAIL rand_q cyc %0d got %h want %h", n, dpack, mpack); end
    checks++;
    if (dsens !== msens) begin errors++; $display("FAIL rand_sens cyc %0d got %b want %b", n, dsens, msens); end
    checks++;
    if (departed_total !== mtotal[CW-1:0]) begin errors++; $display("FAIL rand_total cyc %0d got %0d want %0d", n, departed_total, mtotal); end
    checks++;
    if ({conflict, overflow} !== {mconf, movf}) begin errors++; $display("FAIL rand_flags cyc %0d got %b want %b", n, {conflict, overflow}, {mconf, movf}); end
  endtask

  task automatic test_random();
    bit [4:0] mask;
    int left;
    bit [4:0] phases [3] = '{5'b10000, 5'b00011, 5'b01100};
    do_reset();
    left = 0; mask = '0;
    for (int n = 0; n < 2000; n++) begin
      if (left == 0) begin
        mask = legal[$urandom_range(0, 4)] & 5'($urandom);
        left = $urandom_range(1, 20);
        for (int i = 0; i < 5; i++)
          lt[i] = !mask[i] ? red : (($urandom_range(0, 3) == 0) ? yellow : green);
      end
      left--;
      for (int i = 0; i < 5; i++) arr[i] = ($urandom_range(0, 2) == 0);
      step();
      check_vs_model(n);
    end
    arr = '0;
    for (int p = 0; p < 3; p++) begin
      for (int i = 0; i < 5; i++) lt[i] = phases[p][i] ? green : red;
      for (int k = 0; k < 40; k++) begin
        step();
        check_vs_model(2000 + p * 40 + k);
      end
    end
    all_red();
    step();
    checks++;
    if ({dq[0], dq[1], dq[2], dq[3], dq[4]} !== 20'h0) begin errors++; $display("FAIL drain_empty got %h want 00000", {dq[0], dq[1], dq[2], dq[3], dq[4]}); end
    do_reset();
    for (int n = 0; n < 300; n++) begin
      for (int i = 0; i < 5; i++) begin
        lt[i] = ($urandom_range(0, 5) != 0) ? red : (($urandom_range(0, 1) == 0) ? yellow : green);
        arr[i] = ($urandom_range(0, 1) == 0);
      end
      step();
      check_vs_model(5000 + n);
    end
    arr = '0; all_red();
  endtask

  task automatic test_async_reset();
    do_reset();
    arr = 5'h1f; lt[4] = green;
    repeat (5) step();
    arr = '0; all_red();
    @(negedge clk);
    reset = 1'b0;
    #1;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (dq[i] !== 4'd0) begin errors++; $display("FAIL async_q lane %0d got %0d want 0", i, dq[i]); end
    end
    checks++;
    if (dsens !== 5'b0) begin errors++; $display("FAIL async_sens got %b want 00000", dsens); end
    checks++;
    if (departed_total !== 16'd0) begin errors++; $display("FAIL async_total got %0d want 0", departed_total); end
    model_reset();
    #2;
    reset = 1'b1;
    arr[2] = 1'b1;
    step();
    arr = '0;
    checks++;
    if (w_left_q !== 4'd1) begin errors++; $display("FAIL async_first_arrival got %0d want 1", w_left_q); end
  endtask

  initial begin
    cyc = 0;
    arr = '0;
    all_red();
    reset = 1'b0;
    test_reset();
    test_arrivals();
    test_drain();
    test_overflow();
    test_conflict();
    test_random();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/intersection_traffic_model.md
# intersection_traffic_model

Behavioural-synthesizable model of the five-lane intersection that sits on the other side of the traffic light controller. It consumes the five lane light colors, keeps a per-lane car queue fed by arrival pulses, drains queues on green, and drives the five traffic sensors back to the controller. It also flags unsafe light combinations and queue overflows, which makes it both the closed-loop stimulus and the safety checker in controller test benches and board demos.

## Interface
- QDEPTH, 15: maximum cars held per lane queue (1..255).
- DEPART_GAP, 1: minimum cycles between successive departures on one lane while green (1..15).
- CNT_W, 16: width of the total-departures counter.
- clk  in  1  single system clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-low reset. Asserting it low clears all state immediately; deassertion is sampled on clk.
- e_left_arrive, e_str_arrive, w_left_arrive, w_str_arrive, ns_arrive  in  1 each  one car arrives on that lane this cycle.
- e_left_light, e_str_light, w_left_light, w_str_light, ns_light  in  colors (light_package)  current lane light: red, yellow or green.
- e_left_sensor, e_str_sensor, w_left_sensor, w_str_sensor, ns_sensor  out  1 each  lane queue non-empty.
- e_left_q, e_str_q, w_left_q, w_str_q, ns_q  out  $clog2(QDEPTH+1) each  current queue occupancy.
- departed_total  out  CNT_W  cars departed since reset, all lanes; wraps modulo 2^CNT_W.
- conflict  out  1  sticky: an unsafe light combination was seen.
- overflow  out  1  sticky: an arrival was dropped because a queue was full.

## Operation
- Per lane state: queue count q (0..QDEPTH) and gap counter g (0..DEPART_GAP-1).
- Departure condition for a lane: light == green, q > 0 and g == 0. A departing car decrements q by 1 and loads g with DEPART_GAP-1.
- Gap counter: while the light is green and g > 0, g decrements by 1 per cycle. When the light is not green, g is forced to 0, so the first departure occurs in the first green cycle.
- Yellow and red never permit departures.
- Arrivals: if q < QDEPTH, the arrival increments q. If q == QDEPTH and the lane does not depart that cycle, the car is dropped and overflow is set.
- Simultaneous arrival and departure on one lane leave q unchanged. This includes q == QDEPTH, where no drop occurs and overflow is not set.
- Sensor outputs: sensor = (q != 0), decoded from the registered q, so there are no combinational paths from inputs to outputs.
- departed_total adds the number of departures in the cycle (0..5) and wraps.
- Conflict checking: "active" means green or yellow. conflict is set on any cycle where one of the following holds:
  - ns is active together with any other active lane;
  - e_left and w_str are both active;
  - e_str and w_left are both active.
- The legal active sets are {ns}, {e_left,e_str}, {w_left,w_str}, {e_str,w_str}, {e_left,w_left} and their subsets.
- conflict and overflow clear only on reset.

## Timing
- Reset values: all q = 0, all g = 0, all sensors = 0, departed_total = 0, conflict = 0, overflow = 0.
- Reset mid-operation empties all queues immediately (asynchronously). The first arrival after release is counted on the first rising clk edge that samples reset high.
- Arrival latency: arrive high at edge N makes q and the sensor update after edge N, so both are visible in cycle N+1.
- Departure latency: a green light and q = 1 sampled at edge N clear the sensor after edge N.
- Detection latency: conflict and overflow rise in the cycle after the offending edge.
- Drain throughput: one car per DEPART_GAP cycles per lane. Up to five lanes drain in parallel.

## Test plan
- Reset, then 3 arrival pulses on ns_arrive with all lights red -> ns_q = 3, ns_sensor = 1, departed_total = 0, no flags.
- ns_q = 3, DEPART_GAP = 2, ns_light green for 6 cycles -> departures at cycles 0, 2 and 4, ns_q = 0 after cycle 4, ns_sensor drops, departed_total = 3.
- e_str_q = QDEPTH (15) with a red light, one more arrival -> e_str_q stays 15 and overflow = 1. Then green plus an arrival in the same cycle -> q = 15, overflow remains 1.
- ns_light yellow and e_str_light green in the same cycle -> conflict = 1 on the next cycle and stays set. Legal pair e_left green with w_left green, on a fresh reset -> conflict = 0.
- Closed loop with traffic_light_controller, random arrivals on all lanes for 10k cycles -> conflict = 0, and every lane queue empties within a bounded number of cycles after arrivals stop.
- Reset pulled low for half a cycle with all queues non-zero -> all q and sensors = 0 immediately, departed_total = 0.
